// File: rtl/mcu_mem_pkg.sv
// rtl/mcu_mem_pkg.sv - shared clear-FSM type and helpers for the MCU memory subsystem
package mcu_mem_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  // Widest word lane_merge handles; callers zero-extend and truncate around it.
  localparam int MergeBits = 64;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic logic [MergeBits-1:0] lane_merge(
    input logic [MergeBits-1:0] new_data,
    input logic [MergeBits-1:0] old_data,
    input logic [MergeBits-1:0] lane_en,
    input int                   lane_bits
  );
    logic [MergeBits-1:0] merged;
    for (int b = 0; b < MergeBits; b++) begin
      merged[6'(b)] = lane_en[6'(b / lane_bits)] ? new_data[6'(b)] : old_data[6'(b)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/register_bank_rw_if.sv
// rtl/register_bank_rw_if.sv - write, read and clear signals of the register bank
interface register_bank_rw_if #(
  parameter int NrOfBits = 32,
  parameter int LaneBits = 8,
  parameter int Depth    = 32
);
  localparam int AddrBits  = mcu_mem_pkg::clog2(Depth);
  localparam int NrOfLanes = NrOfBits / LaneBits;

  logic                 ClockEnable;
  logic                 Tick;
  logic                 WrEn;
  logic [AddrBits-1:0]  WrAddr;
  logic [NrOfLanes-1:0] WrLaneEn;
  logic [NrOfBits-1:0]  WrData;
  logic [AddrBits-1:0]  RdAddrA;
  logic [NrOfBits-1:0]  RdDataA;
  logic [AddrBits-1:0]  RdAddrB;
  logic [NrOfBits-1:0]  RdDataB;
  logic                 ClearReq;
  logic                 ClearBusy;

  modport master (
    output ClockEnable, Tick, WrEn, WrAddr, WrLaneEn, WrData, RdAddrA, RdAddrB, ClearReq,
    input  RdDataA, RdDataB, ClearBusy
  );

  modport slave (
    input  ClockEnable, Tick, WrEn, WrAddr, WrLaneEn, WrData, RdAddrA, RdAddrB, ClearReq,
    output RdDataA, RdDataB, ClearBusy
  );
endinterface

// File: rtl/register_bank_lane.sv
// rtl/register_bank_lane.sv - one LaneBits-wide storage lane clocked on the selected edge
module register_bank_lane #(
  parameter int ActiveLevel = 1,
  parameter int LaneBits    = 8
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                lane_en,
  input  logic [LaneBits-1:0] lane_d,
  output logic [LaneBits-1:0] lane_q
);

  if (ActiveLevel != 0) begin : g_pos
    always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        lane_q <= '0;
      end else if (lane_en) begin
        lane_q <= lane_d;
      end
    end
  end else begin : g_neg
    always_ff @(negedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        lane_q <= '0;
      end else if (lane_en) begin
        lane_q <= lane_d;
      end
    end
  end

endmodule

// File: rtl/register_bank_rw.sv
// rtl/register_bank_rw.sv - register bank: lane-masked write port, two async read ports, clear sweep
module register_bank_rw
  import mcu_mem_pkg::*;
#(
  parameter int ActiveLevel = 1,
  parameter int NrOfBits    = 32,
  parameter int LaneBits    = 8,
  parameter int Depth       = 32,
  parameter int ZeroEntry0  = 1,
  parameter int Bypass      = 0
) (
  input logic               Clock,
  input logic               ResetN,
  register_bank_rw_if.slave bus
);

  localparam int AddrBits  = clog2(Depth);
  localparam int NrOfLanes = NrOfBits / LaneBits;
  localparam int Slots     = 1 << AddrBits;

  clr_state_t                     state_q;
  clr_state_t                     state_d;
  logic [AddrBits-1:0]            ptr_q;
  logic [AddrBits-1:0]            ptr_d;
  logic                           qe;
  logic                           sweeping;
  logic                           wr_ok;
  logic [Slots-1:0]               addr_ok;
  logic [Slots-1:0][NrOfBits-1:0] entry_q;
  logic [NrOfBits-1:0]            bypass_data;

  assign qe       = bus.ClockEnable & bus.Tick;
  assign sweeping = (state_q == CLR_SWEEP);
  assign wr_ok    = bus.WrEn & addr_ok[bus.WrAddr] & ~sweeping;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (qe) begin
      case (state_q)
        CLR_IDLE: begin
          if (bus.ClearReq) begin
            state_d = CLR_SWEEP;
            ptr_d   = '0;
          end
        end
        CLR_SWEEP: begin
          if (ptr_q == AddrBits'(Depth - 1)) begin
            state_d = CLR_IDLE;
          end else begin
            ptr_d = ptr_q + AddrBits'(1);
          end
        end
        default: state_d = CLR_IDLE;
      endcase
    end
  end

  if (ActiveLevel != 0) begin : g_fsm_pos
    always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        state_q <= CLR_IDLE;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
      end
    end
  end else begin : g_fsm_neg
    always_ff @(negedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        state_q <= CLR_IDLE;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
      end
    end
  end

  // Slots past Depth (and entry 0 when hardwired) get no storage, so writes there vanish.
  for (genvar e = 0; e < Slots; e++) begin : g_entry
    if (e < Depth && !(ZeroEntry0 != 0 && e == 0)) begin : g_store
      logic hit_wr;
      logic hit_clr;
      assign addr_ok[e] = 1'b1;
      assign hit_wr     = wr_ok && (bus.WrAddr == AddrBits'(e));
      assign hit_clr    = sweeping && (ptr_q == AddrBits'(e));
      for (genvar l = 0; l < NrOfLanes; l++) begin : g_lane
        register_bank_lane #(
          .ActiveLevel (ActiveLevel),
          .LaneBits    (LaneBits)
        ) u_lane (
          .Clock   (Clock),
          .ResetN  (ResetN),
          .lane_en (qe && (hit_clr || (hit_wr && bus.WrLaneEn[l]))),
          .lane_d  (hit_clr ? {LaneBits{1'b0}} : bus.WrData[l*LaneBits +: LaneBits]),
          .lane_q  (entry_q[e][l*LaneBits +: LaneBits])
        );
      end
    end else begin : g_zero
      assign addr_ok[e] = 1'b0;
      assign entry_q[e] = '0;
    end
  end

  assign bypass_data = NrOfBits'(lane_merge(MergeBits'(bus.WrData), MergeBits'(entry_q[bus.WrAddr]),
                                            MergeBits'(bus.WrLaneEn), LaneBits));

  always_comb begin
    bus.RdDataA = entry_q[bus.RdAddrA];
    bus.RdDataB = entry_q[bus.RdAddrB];
    if (Bypass != 0 && wr_ok) begin
      if (bus.RdAddrA == bus.WrAddr) bus.RdDataA = bypass_data;
      if (bus.RdAddrB == bus.WrAddr) bus.RdDataB = bypass_data;
    end
  end

  assign bus.ClearBusy = sweeping;

endmodule

// File: tb/tb_register_bank_rw.sv
// tb/tb_register_bank_rw.sv - self-checking bench for register_bank_rw (rising/bypass and falling/no-bypass instances)
module tb_register_bank_rw;

  typedef struct packed {
    logic        ce;
    logic        tick;
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  lane;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        clr;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stim_t       st [2];
  logic [31:0] rd_a [2];
  logic [31:0] rd_b [2];
  logic        busy [2];

  register_bank_rw_if #(.NrOfBits(32), .LaneBits(8), .Depth(32)) if_a ();
  register_bank_rw_if #(.NrOfBits(32), .LaneBits(8), .Depth(12)) if_b ();

  register_bank_rw #(
    .ActiveLevel(1), .NrOfBits(32), .LaneBits(8), .Depth(32), .ZeroEntry0(1), .Bypass(1)
  ) dut_a (.Clock(clk), .ResetN(rst_n), .bus(if_a));

  register_bank_rw #(
    .ActiveLevel(0), .NrOfBits(32), .LaneBits(8), .Depth(12), .ZeroEntry0(0), .Bypass(0)
  ) dut_b (.Clock(clk), .ResetN(rst_n), .bus(if_b));

  assign if_a.ClockEnable = st[0].ce;
  assign if_a.Tick        = st[0].tick;
  assign if_a.WrEn        = st[0].we;
  assign if_a.WrAddr      = st[0].wa;
  assign if_a.WrLaneEn    = st[0].lane;
  assign if_a.WrData      = st[0].wd;
  assign if_a.RdAddrA     = st[0].ra;
  assign if_a.RdAddrB     = st[0].rb;
  assign if_a.ClearReq    = st[0].clr;
  assign rd_a[0]          = if_a.RdDataA;
  assign rd_b[0]          = if_a.RdDataB;
  assign busy[0]          = if_a.ClearBusy;

  assign if_b.ClockEnable = st[1].ce;
  assign if_b.Tick        = st[1].tick;
  assign if_b.WrEn        = st[1].we;
  assign if_b.WrAddr      = st[1].wa[3:0];
  assign if_b.WrLaneEn    = st[1].lane;
  assign if_b.WrData      = st[1].wd;
  assign if_b.RdAddrA     = st[1].ra[3:0];
  assign if_b.RdAddrB     = st[1].rb[3:0];
  assign if_b.ClearReq    = st[1].clr;
  assign rd_a[1]          = if_b.RdDataA;
  assign rd_b[1]          = if_b.RdDataB;
  assign busy[1]          = if_b.ClearBusy;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: plain array per instance plus a count of sweep steps still owed.
  logic [31:0] mem [2][32];
  int          clear_left [2];
  int          depth_c [2] = '{32, 12};
  bit          z0_c [2]    = '{1'b1, 1'b0};
  bit          byp_c [2]   = '{1'b1, 1'b0};

  vec_t vecs [13];
  int   qe_cnt;
  logic tk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic stim_t mk(input logic ce, input logic tick, input logic we, input int wa,
                               input logic [3:0] lane, input logic [31:0] wd,
                               input int ra, input int rb, input logic clr);
    stim_t s;
    s.ce = ce; s.tick = tick; s.we = we; s.wa = 5'(wa); s.lane = lane;
    s.wd = wd; s.ra = 5'(ra); s.rb = 5'(rb); s.clr = clr;
    return s;
  endfunction

  function automatic stim_t rand_stim(input int k);
    stim_t s;
    int    amax = (k == 0) ? 31 : 15;
    s.ce   = ($urandom_range(0, 9) != 0);
    s.tick = ($urandom_range(0, 3) != 0);
    s.we   = 1'($urandom_range(0, 1));
    s.wa   = 5'($urandom_range(0, amax));
    s.lane = 4'($urandom_range(0, 15));
    s.wd   = $urandom;
    s.ra   = 5'($urandom_range(0, amax));
    s.rb   = 5'($urandom_range(0, amax));
    s.clr  = ($urandom_range(0, 39) == 0);
    return s;
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] nd, input logic [31:0] od, input logic [3:0] lane);
    logic [31:0] m = '0;
    for (int l = 0; l < 4; l++) if (lane[l]) m[l*8 +: 8] = 8'hFF;
    return (nd & m) | (od & ~m);
  endfunction

  function automatic bit wvalid(input int k);
    int a = int'(st[k].wa);
    return st[k].we && a < depth_c[k] && !(z0_c[k] && a == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input int addr);
    if (addr >= depth_c[k] || (z0_c[k] && addr == 0)) return 32'h0;
    if (byp_c[k] && clear_left[k] == 0 && wvalid(k) && addr == int'(st[k].wa))
      return merged(st[k].wd, mem[k][addr], st[k].lane);
    return mem[k][addr];
  endfunction

  function automatic void model_edge(input int k);
    if (!(st[k].ce && st[k].tick)) return;
    if (clear_left[k] > 0) begin
      mem[k][depth_c[k] - clear_left[k]] = 32'h0;
      clear_left[k]--;
    end else begin
      if (wvalid(k)) mem[k][st[k].wa] = merged(st[k].wd, mem[k][st[k].wa], st[k].lane);
      if (st[k].clr) clear_left[k] = depth_c[k];
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      clear_left[k] = 0;
      for (int i = 0; i < 32; i++) mem[k][i] = 32'h0;
    end
  endfunction

  task automatic step_edge(input int k);
    if (k == 0) @(posedge clk);
    else @(negedge clk);
    #1;
  endtask

  task automatic run_step(input int k);
    #1;
    check($sformatf("model_rd_a[%0d]", k), rd_a[k], exp_rd(k, int'(st[k].ra)));
    check($sformatf("model_rd_b[%0d]", k), rd_b[k], exp_rd(k, int'(st[k].rb)));
    check($sformatf("model_busy[%0d]", k), 32'(busy[k]), 32'(clear_left[k] > 0));
    step_edge(k);
    model_edge(k);
  endtask

  initial begin
    st[0] = '0;
    st[1] = '0;
    vecs[0]  = '{mk(1, 1, 1, 5, 4'hF, 32'hDEADBEEF, 5, 0, 0), 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{mk(1, 1, 0, 5, 4'hF, 32'h0,        5, 5, 0), 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{mk(1, 1, 1, 7, 4'hF, 32'h11223344, 7, 5, 0), 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{mk(1, 1, 1, 7, 4'h5, 32'hAABBCCDD, 7, 7, 0), 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{mk(1, 1, 0, 7, 4'h0, 32'h0,        7, 7, 0), 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{mk(1, 1, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 0), 32'h0,        32'h0,        1'b0};
    vecs[6]  = '{mk(1, 1, 0, 0, 4'h0, 32'h0,        0, 7, 0), 32'h0,        32'h11BB33DD, 1'b0};
    vecs[7]  = '{mk(1, 0, 1, 3, 4'hF, 32'h5A5A5A5A, 3, 3, 0), 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
    vecs[8]  = '{mk(1, 1, 0, 3, 4'h0, 32'h0,        3, 3, 0), 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{mk(0, 1, 1, 3, 4'hF, 32'h5A5A5A5A, 3, 5, 0), 32'h5A5A5A5A, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{mk(1, 1, 0, 3, 4'h0, 32'h0,        3, 5, 0), 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[11] = '{mk(1, 1, 1, 3, 4'hF, 32'h5A5A5A5A, 3, 3, 0), 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
    vecs[12] = '{mk(1, 1, 0, 3, 4'h0, 32'h0,        3, 3, 0), 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};

    #12;
    check("reset_a_rd_a", rd_a[0], 32'h0);
    check("reset_a_rd_b", rd_b[0], 32'h0);
    check("reset_a_busy", 32'(busy[0]), 32'h0);
    check("reset_b_rd_a", rd_a[1], 32'h0);
    check("reset_b_busy", 32'(busy[1]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      st[0] = vecs[i].s;
      #1;
      check($sformatf("vec%0d_rd_a", i), rd_a[0], vecs[i].exp_a);
      check($sformatf("vec%0d_rd_b", i), rd_b[0], vecs[i].exp_b);
      check($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(vecs[i].exp_busy));
      step_edge(0);
    end
    st[0] = '0;

    // Falling-edge instance without bypass or hardwired entry 0.
    @(negedge clk);
    #1;
    st[1] = mk(1, 1, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 3, 0);
    #1;
    check("b_pre_edge_addr0", rd_a[1], 32'h0);
    @(posedge clk);
    #1;
    check("b_after_rise_addr0", rd_a[1], 32'h0);
    @(negedge clk);
    #1;
    check("b_after_fall_addr0", rd_a[1], 32'hFFFFFFFF);
    st[1] = mk(1, 1, 1, 3, 4'hF, 32'h5A5A5A5A, 0, 3, 0);
    #1;
    check("b_no_bypass_old", rd_b[1], 32'h0);
    @(negedge clk);
    #1;
    check("b_after_fall_addr3", rd_b[1], 32'h5A5A5A5A);
    st[1] = mk(1, 1, 1, 13, 4'hF, 32'h12345678, 13, 0, 0);
    @(negedge clk);
    #1;
    check("b_out_of_range_13", rd_a[1], 32'h0);
    check("b_entry0_kept", rd_b[1], 32'hFFFFFFFF);
    st[1] = '0;

    // Clear sweep with a simultaneous write, non-qualified edges and a mid-sweep ClearReq.
    @(posedge clk);
    #1;
    st[0] = mk(1, 1, 1, 9, 4'hF, 32'h12345678, 9, 0, 1);
    #1;
    check("sweep_idle_busy", 32'(busy[0]), 32'h0);
    step_edge(0);
    check("sweep_rise", 32'(busy[0]), 32'h1);
    st[0] = mk(1, 1, 0, 9, 4'h0, 32'h0, 9, 0, 0);
    #1;
    check("write_with_clear_lands", rd_a[0], 32'h12345678);
    qe_cnt = 0;
    for (int it = 0; it < 200; it++) begin
      tk = ((it % 3) != 2);
      st[0] = mk(1, tk, 1, 20, 4'hF, 32'hFFFFFFFF, 20, 9, qe_cnt == 15);
      step_edge(0);
      if (tk) qe_cnt++;
      if (!busy[0]) break;
    end
    check("sweep_len", 32'(qe_cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      st[0] = mk(1, 1, 0, 0, 4'h0, 32'h0, i, 31 - i, 0);
      #1;
      check($sformatf("sweep_zero_%0d", i), rd_a[0], 32'h0);
    end

    // Async reset in the middle of a sweep.
    @(posedge clk);
    #1;
    st[0] = mk(1, 1, 1, 30, 4'hF, 32'hCAFEF00D, 30, 0, 0);
    step_edge(0);
    st[0] = mk(1, 1, 0, 0, 4'h0, 32'h0, 30, 0, 1);
    step_edge(0);
    st[0].clr = 1'b0;
    for (int i = 0; i < 9; i++) step_edge(0);
    st[1] = mk(0, 0, 0, 0, 4'h0, 32'h0, 0, 3, 0);
    #1;
    check("pre_reset_busy", 32'(busy[0]), 32'h1);
    check("pre_reset_data", rd_a[0], 32'hCAFEF00D);
    check("pre_reset_b_data", rd_a[1], 32'hFFFFFFFF);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(busy[0]), 32'h0);
    check("mid_reset_rd_a", rd_a[0], 32'h0);
    check("mid_reset_b_rd_a", rd_a[1], 32'h0);
    check("mid_reset_b_rd_b", rd_b[1], 32'h0);
    #3 rst_n = 1'b1;
    model_reset();

    st[0] = mk(1, 1, 1, 5, 4'hF, 32'hDEADBEEF, 5, 5, 0);
    run_step(0);
    st[0] = mk(1, 1, 0, 0, 4'h0, 32'h0, 5, 0, 0);
    #1;
    check("post_reset_read5", rd_a[0], 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      st[0] = rand_stim(0);
      run_step(0);
    end
    st[0] = '0;
    for (int i = 0; i < 300; i++) begin
      st[1] = rand_stim(1);
      run_step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
